reset_sequencer: RTL and testbench

Sequences reset release for multiple downstream clock-domain-local blocks (SPI master, accelerometer configuration engine, UART/reporting path) after the global reset. It sits directly behind the system clock/reset source, holds every domain in reset for a fixed guard interval, then releases domains one at a time in index order. It waits for each domain's ready acknowledge before releasing the next, and flags a watchdog fault if a domain never reports ready.

---
 rtl/reset_sequencer.sv | 176 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset release sequencer: guard interval with every domain held in reset, then in-order
// release gated by per-domain ready. The watchdog/FAULT path is built only with RESET_SEQ_WATCHDOG_EN.
module reset_sequencer #(
  parameter int NUM_DOMAINS    = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   soft_rst_req_i,
  input  logic [NUM_DOMAINS-1:0] ready_i,
  output logic [NUM_DOMAINS-1:0] dom_rst_o,
  output logic [NUM_DOMAINS-1:0] dom_nrst_o,
  output logic                   all_ready_o,
  output logic                   busy_o,
  output logic                   timeout_o,
  output logic [2:0]             fail_idx_o
);

  localparam logic [2:0] ST_HOLD     = 3'd0;
  localparam logic [2:0] ST_RELEASE  = 3'd1;
  localparam logic [2:0] ST_WAIT_RDY = 3'd2;
  localparam logic [2:0] ST_DONE     = 3'd3;
  localparam logic [2:0] ST_FAULT    = 3'd4;

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam int CNT_SPAN = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
`else
  localparam int CNT_SPAN = HOLD_CYCLES;
`endif
  localparam int CNT_W = (CNT_SPAN > 1) ? $clog2(CNT_SPAN) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef RESET_SEQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
  localparam logic [2:0] LAST_IDX = 3'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] ALL_ONES = {NUM_DOMAINS{1'b1}};

  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
  logic                   all_ready_q, all_ready_d;
  logic                   busy_q, busy_d;
  logic                   timeout_q, timeout_d;
  logic [2:0]             fail_idx_q, fail_idx_d;

  logic [NUM_DOMAINS-1:0] idx_mask_s;
  logic                   cur_ready_s;

  // One-hot of the domain currently being sequenced; only its ready bit is ever looked at.
  always_comb begin
    idx_mask_s  = NUM_DOMAINS'(1'b1) << idx_q;
    cur_ready_s = |(ready_i & idx_mask_s);
  end

  // Next-state logic; a soft restart request overrides every other event.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    dom_rst_d   = dom_rst_q;
    all_ready_d = all_ready_q;
    busy_d      = busy_q;
    timeout_d   = timeout_q;
    fail_idx_d  = fail_idx_q;
    if (soft_rst_req_i) begin
      state_d     = ST_HOLD;
      cnt_d       = '0;
      idx_d       = 3'd0;
      dom_rst_d   = ALL_ONES;
      all_ready_d = 1'b0;
      busy_d      = 1'b1;
      timeout_d   = 1'b0;
      fail_idx_d  = 3'd0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          dom_rst_d = dom_rst_q & ~idx_mask_s;
          cnt_d     = '0;
          state_d   = ST_WAIT_RDY;
        end
        ST_WAIT_RDY: begin
          // A ready seen on the final watchdog cycle still counts as an acknowledge.
          if (cur_ready_s) begin
            if (idx_q == LAST_IDX) begin
              state_d     = ST_DONE;
              all_ready_d = 1'b1;
              busy_d      = 1'b0;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = ST_RELEASE;
            end
          end
`ifdef RESET_SEQ_WATCHDOG_EN
          else if (cnt_q == TIMEOUT_LAST) begin
            state_d    = ST_FAULT;
            dom_rst_d  = dom_rst_q | idx_mask_s;
            timeout_d  = 1'b1;
            fail_idx_d = idx_q;
            busy_d     = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          else begin
            cnt_d = cnt_q;
          end
`endif
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d     = ST_HOLD;
          cnt_d       = '0;
          idx_d       = 3'd0;
          dom_rst_d   = ALL_ONES;
          all_ready_d = 1'b0;
          busy_d      = 1'b1;
          timeout_d   = 1'b0;
          fail_idx_d  = 3'd0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      dom_rst_q   <= ALL_ONES;
      all_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      timeout_q   <= 1'b0;
      fail_idx_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      dom_rst_q   <= dom_rst_d;
      all_ready_q <= all_ready_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      fail_idx_q  <= fail_idx_d;
    end
  end

  assign dom_rst_o   = dom_rst_q;
  assign dom_nrst_o  = ~dom_rst_q;
  assign all_ready_o = all_ready_q;
  assign busy_o      = busy_q;
`ifdef RESET_SEQ_WATCHDOG_EN
  assign timeout_o   = timeout_q;
  assign fail_idx_o  = fail_idx_q;
`else
  assign timeout_o   = 1'b0;
  assign fail_idx_o  = 3'd0;
  logic unused_wd_s;
  assign unused_wd_s = timeout_q ^ (^fail_idx_q);
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a timeline model predicts every output change
// (edge number + value) from the ready plan; a monitor matches DUT output changes against it.
module tb_reset_sequencer;
  localparam int ND    = 3;
  localparam int HOLD  = 16;
  localparam int TMO   = 64;
  localparam int NEVER = 1 << 30;
`ifdef RESET_SEQ_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  localparam logic [11:0] RST_V = {3'b111, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000};

  typedef struct { int e; logic [11:0] v; } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          soft_rst_req;
  logic [ND-1:0] ready;
  logic [ND-1:0] dom_rst, dom_nrst;
  logic          all_ready, busy, timeout;
  logic [2:0]    fail_idx;

  ev_t         exp_q[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          ready_at [ND] = '{NEVER, NEVER, NEVER};
  bit          noise = 1'b0;
  logic [11:0] last_exp = RST_V;
  logic [11:0] prev_v = RST_V;
  logic [11:0] mon_cur;
  ev_t         mon_ev;
  int          d [ND];
  bit          pre [ND];
  int          t0;

  reset_sequencer #(.NUM_DOMAINS(ND), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .soft_rst_req_i(soft_rst_req), .ready_i(ready),
    .dom_rst_o(dom_rst), .dom_nrst_o(dom_nrst), .all_ready_o(all_ready), .busy_o(busy),
    .timeout_o(timeout), .fail_idx_o(fail_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] exp_outs(logic [2:0] dr, logic ar, logic bz, logic to, logic [2:0] fi);
    return {dr, ar, bz, to, fi, ~dr};
  endfunction

  function automatic logic [11:0] outs_now();
    return {dom_rst, all_ready, busy, timeout, fail_idx, dom_nrst};
  endfunction

  function automatic void push_ev(int e, logic [11:0] v);
    ev_t ev;
    ev.e = e;
    ev.v = v;
    exp_q.push_back(ev);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: outputs %h, expected %h", name, act, req);
    end
  endtask

  // Ready driver: bit k is high for every edge numbered ready_at[k] or later.
  initial begin
    ready = '0;
    forever begin
      @(negedge clk);
      if (noise) ready = 3'($urandom);
      else for (int k = 0; k < ND; k++) ready[k] = (cyc + 1 >= ready_at[k]);
    end
  end

  // Monitor: every change of the output vector must be the next predicted event.
  initial forever begin
    @(negedge clk);
    mon_cur = outs_now();
    if (mon_cur !== prev_v) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: edge %0d outputs %h, expected unchanged %h", cyc, mon_cur, prev_v);
      end else begin
        mon_ev = exp_q.pop_front();
        last_exp = mon_ev.v;
        if (mon_ev.e != cyc || mon_ev.v !== mon_cur) begin
          n_fail++;
          $display("FAIL output_event: edge %0d outputs %h, expected edge %0d outputs %h",
                   cyc, mon_cur, mon_ev.e, mon_ev.v);
        end
      end
      prev_v = mon_cur;
    end
  end

  // Timeline model: release k at edge r, ack when ready first sampled after r, fault at r+TMO.
  task automatic plan(input int start, input int dly [ND], input bit early [ND]);
    int r, s, want, kk;
    logic [2:0] dr;
    r  = start + HOLD + 1;
    dr = 3'b111;
    kk = ND;
    for (int k = 0; k < ND; k++) begin
      if (dly[k] >= NEVER) want = NEVER;
      else if (early[k]) want = start + 2 + int'($urandom_range(10, 0));
      else want = r + dly[k];
      ready_at[k] = want;
      dr[k] = 1'b0;
      push_ev(r, exp_outs(dr, 1'b0, 1'b1, 1'b0, 3'd0));
      s = (want > r + 1) ? want : r + 1;
      if (WD && (s - r > TMO)) begin
        dr[k] = 1'b1;
        push_ev(r + TMO, exp_outs(dr, 1'b0, 1'b0, 1'b1, 3'(k)));
        kk = k;
        break;
      end
      if (!WD && s >= NEVER) begin
        kk = k;
        break;
      end
      if (k == ND - 1) push_ev(s, exp_outs(dr, 1'b1, 1'b0, 1'b0, 3'd0));
      else r = s + 1;
    end
    for (int j = kk + 1; j < ND; j++) ready_at[j] = r + 2;
  endtask

  task automatic cancel_from(input int e);
    logic [11:0] tail;
    while (exp_q.size() != 0 && exp_q[$].e >= e) void'(exp_q.pop_back());
    tail = (exp_q.size() != 0) ? exp_q[$].v : last_exp;
    if (tail !== RST_V) push_ev(e, RST_V);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_event: %0d predicted changes not seen, next expected edge %0d outputs %h",
               exp_q.size(), exp_q[0].e, exp_q[0].v);
      exp_q.delete();
    end
  endtask

  task automatic soft_restart(input int hold, output int start);
    soft_rst_req = 1'b1;
    cancel_from(cyc + 1);
    tick(hold);
    soft_rst_req = 1'b0;
    start = cyc;
  endtask

  task automatic async_reset(input int hold, output int start);
    #1;
    rst = 1'b1;
    cancel_from(cyc + 1);
    #1;
    check("async_reset_immediate", outs_now(), RST_V);
    tick(hold);
    rst = 1'b0;
    start = cyc;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, n_chk %0d", n_chk);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    soft_rst_req = 1'b0;
    tick(3);
    check("reset_state", outs_now(), RST_V);
    t0 = cyc;
    rst = 1'b0;
    d = '{5, 5, 5};
    pre = '{1'b0, 1'b0, 1'b0};
    plan(t0, d, pre);
    drain(500);
    noise = 1'b1;
    tick(20);
    noise = 1'b0;
    check("done_holds", outs_now(), exp_outs(3'b000, 1'b1, 1'b0, 1'b0, 3'd0));

    for (int it = 0; it < 6; it++) begin
      soft_restart(1 + int'($urandom_range(2, 0)), t0);
      for (int k = 0; k < ND; k++) begin
        d[k]   = int'($urandom_range(12, 1));
        pre[k] = ($urandom_range(3, 0) == 0);
      end
      plan(t0, d, pre);
      drain(500);
    end

`ifdef RESET_SEQ_WATCHDOG_EN
    soft_restart(1, t0);
    d = '{int'($urandom_range(8, 1)), NEVER, 3};
    pre = '{1'b0, 1'b0, 1'b0};
    plan(t0, d, pre);
    drain(500);
    noise = 1'b1;
    tick(15);
    noise = 1'b0;
    check("fault_holds", outs_now(), exp_outs(3'b110, 1'b0, 1'b0, 1'b1, 3'd1));
    soft_restart(1, t0);
    d = '{2, TMO, 4};
    plan(t0, d, pre);
    drain(500);
    soft_restart(1, t0);
    d = '{2, TMO + 1, 4};
    plan(t0, d, pre);
    drain(500);
    soft_restart(2, t0);
    d = '{TMO + 1, 1, 1};
    plan(t0, d, pre);
    drain(500);
    soft_restart(1, t0);
    d = '{1, 1, NEVER};
    plan(t0, d, pre);
    drain(500);
`else
    soft_restart(1, t0);
    d = '{NEVER, 1, 1};
    pre = '{1'b0, 1'b0, 1'b0};
    plan(t0, d, pre);
    tick(5000);
    drain(10);
    check("no_watchdog_stuck", outs_now(), exp_outs(3'b110, 1'b0, 1'b1, 1'b0, 3'd0));
`endif

    soft_restart(1, t0);
    d = '{3, 30, 3};
    pre = '{1'b0, 1'b0, 1'b0};
    plan(t0, d, pre);
    while (cyc < t0 + HOLD + 1 + 3 + 1 + 10) tick(1);
    soft_restart(2, t0);
    d = '{4, 6, 2};
    plan(t0, d, pre);
    drain(500);

    soft_restart(1, t0);
    d = '{2, 2, 40};
    plan(t0, d, pre);
    while (cyc < t0 + HOLD + 1 + 6 + 10) tick(1);
    async_reset(3, t0);
    d = '{5, 5, 5};
    plan(t0, d, pre);
    drain(500);
    check("final_done", outs_now(), exp_outs(3'b000, 1'b1, 1'b0, 1'b0, 3'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
